// File: rtl/mem_pkg.sv
// Shared memory-path definitions: load/store opcodes, widths, the store-buffer
// entry layout and the byte-lane helpers used at enqueue and at query time.
package mem_pkg;

  localparam int ADDR_WIDTH  = 15;
  localparam int DATA_WIDTH  = 32;
  localparam int WADDR_WIDTH = ADDR_WIDTH - 2;

  localparam logic [6:0] OP_LB  = 7'd11;
  localparam logic [6:0] OP_LH  = 7'd12;
  localparam logic [6:0] OP_LW  = 7'd13;
  localparam logic [6:0] OP_LBU = 7'd14;
  localparam logic [6:0] OP_LHU = 7'd15;
  localparam logic [6:0] OP_SB  = 7'd16;
  localparam logic [6:0] OP_SH  = 7'd17;
  localparam logic [6:0] OP_SW  = 7'd18;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_WRITE = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   spec;
    logic [WADDR_WIDTH-1:0] waddr;
    logic [3:0]             be;
    logic [DATA_WIDTH-1:0]  data;
  } sb_entry_t;

  function automatic logic is_store(input logic [6:0] opcode);
    return (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  endfunction

  // Misaligned halfword/word accesses keep the aligned lane pattern.
  function automatic logic [3:0] lane_mask(input logic [6:0] opcode, input logic [1:0] a);
    case (opcode)
      OP_LB, OP_LBU, OP_SB: lane_mask = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default:              lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [6:0] opcode,
                                                     input logic [1:0] a,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (opcode)
      OP_SB:   lane_data = {24'b0, d[7:0]} << {a, 3'b000};
      OP_SH:   lane_data = a[1] ? {d[15:0], 16'b0} : {16'b0, d[15:0]};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/store_addr_match.sv
// One store-buffer entry versus one load query. With STORE_BUFFER_BYTE_MATCH_EN
// defined the byte lanes must also overlap; otherwise the match is word-granular.
module store_addr_match
  import mem_pkg::*;
(
  input  logic                   entry_valid,
  input  logic [WADDR_WIDTH-1:0] entry_waddr,
  input  logic [3:0]             entry_be,
  input  logic [WADDR_WIDTH-1:0] query_waddr,
  input  logic [3:0]             query_mask,
  output logic                   hit
);

`ifdef STORE_BUFFER_BYTE_MATCH_EN
  assign hit = entry_valid && (entry_waddr == query_waddr) && |(entry_be & query_mask);
`else
  logic unused_lanes;
  assign unused_lanes = ^{entry_be, query_mask};
  assign hit = entry_valid && (entry_waddr == query_waddr);
`endif

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed/speculative stores, load-conflict
// lookup and in-order drain to data RAM. Optional macro: STORE_BUFFER_BYTE_MATCH_EN.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  input  logic [6:0]                st_opcode,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [DATA_WIDTH-1:0]     st_data,
  input  logic                      speculative,
  input  logic                      prediction_success,
  input  logic                      prediction_failed,
  input  logic                      search_store_buffer,
  input  logic [ADDR_WIDTH-1:0]     computed_addr,
  input  logic [6:0]                search_opcode,
  output logic                      store_buffer_match,
  output logic                      full,
  output logic                      mem_wr_valid,
  output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic [3:0]                mem_wr_be,
  input  logic                      mem_wr_ready,
  output mem_pkg::drain_state_e     dbg_state,
  output logic [$clog2(DEPTH):0]    dbg_count
);
  import mem_pkg::*;

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        entries [DEPTH];
  sb_entry_t        new_entry;
  logic [PW-1:0]    head, tail, tail_base, head_inc, load_idx;
  logic [PW:0]      count, count_next, nspec;
  logic             enq, retire, head_ok, next_ok, load_mem;
  logic [DEPTH:0]   hits;
  logic [3:0]       query_mask;
  drain_state_e     state, state_next;

  // Incoming store: resolution in the same cycle applies to it as well.
  always_comb begin
    enq = st_valid && is_store(st_opcode) && !full && !(prediction_failed && speculative);
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.spec  = speculative && !prediction_success;
    new_entry.waddr = st_addr[ADDR_WIDTH-1:2];
    new_entry.be    = lane_mask(st_opcode, st_addr[1:0]);
    new_entry.data  = lane_data(st_opcode, st_addr[1:0], st_data);
  end

  // Spec entries are the youngest contiguous run, so a flush just rewinds tail.
  always_comb begin
    nspec = '0;
    if (prediction_failed) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid && entries[i].spec) nspec = nspec + (PW+1)'(1);
      end
    end
    tail_base  = tail - nspec[PW-1:0];
    retire     = mem_wr_valid && mem_wr_ready;
    count_next = count - nspec - (PW+1)'(retire) + (PW+1)'(enq);
    head_inc   = head + PW'(1);
    head_ok    = entries[head].valid && !entries[head].spec;
    next_ok    = entries[head_inc].valid && !entries[head_inc].spec;
  end

  // mem_wr_valid/mem_wr_ready: a write transfers on every cycle both are high;
  // while valid is high and ready is low, addr, data and be are held stable.
  always_ff @(posedge clk) begin
    if (reset) state <= DRAIN_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DRAIN_IDLE:  if (head_ok) state_next = DRAIN_WRITE;
      DRAIN_WRITE: if (mem_wr_ready) state_next = next_ok ? DRAIN_WRITE : DRAIN_IDLE;
      default:     state_next = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    load_mem = 1'b0;
    load_idx = head;
    case (state)
      DRAIN_IDLE:  load_mem = head_ok;
      DRAIN_WRITE: begin
        load_mem = mem_wr_ready && next_ok;
        load_idx = head_inc;
      end
      default: load_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      mem_wr_be    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (prediction_success) entries[i].spec <= 1'b0;
        if (prediction_failed && entries[i].spec) begin
          entries[i].valid <= 1'b0;
          entries[i].spec  <= 1'b0;
        end
      end
      if (retire) entries[head].valid <= 1'b0;
      // The enqueue slot can never be the retiring head: that would need a full buffer.
      if (enq) entries[tail_base] <= new_entry;
      head  <= retire ? head_inc : head;
      tail  <= enq ? tail_base + PW'(1) : tail_base;
      count <= count_next;
      full  <= (count_next == (PW+1)'(DEPTH));
      mem_wr_valid <= (state_next == DRAIN_WRITE);
      if (load_mem) begin
        mem_wr_addr <= {entries[load_idx].waddr, 2'b00};
        mem_wr_data <= entries[load_idx].data;
        mem_wr_be   <= entries[load_idx].be;
      end
    end
  end

  assign query_mask = lane_mask(search_opcode, computed_addr[1:0]);

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    store_addr_match u_match (
      .entry_valid (entries[g].valid),
      .entry_waddr (entries[g].waddr),
      .entry_be    (entries[g].be),
      .query_waddr (computed_addr[ADDR_WIDTH-1:2]),
      .query_mask  (query_mask),
      .hit         (hits[g])
    );
  end

  store_addr_match u_bypass (
    .entry_valid (enq),
    .entry_waddr (new_entry.waddr),
    .entry_be    (new_entry.be),
    .query_waddr (computed_addr[ADDR_WIDTH-1:2]),
    .query_mask  (query_mask),
    .hit         (hits[DEPTH])
  );

  assign store_buffer_match = search_store_buffer && (|hits) && !reset;
  assign dbg_state          = state;
  assign dbg_count          = count;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic scored
// against a queue model of the buffer contents.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [6:0] LB = 7'd11, LH = 7'd12, LW = 7'd13, LBU = 7'd14, LHU = 7'd15;
  localparam logic [6:0] SB = 7'd16, SH = 7'd17, SW = 7'd18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [6:0]  st_opcode = '0;
  logic [14:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        speculative = 1'b0;
  logic        prediction_success = 1'b0;
  logic        prediction_failed = 1'b0;
  logic        search_store_buffer = 1'b0;
  logic [14:0] computed_addr = '0;
  logic [6:0]  search_opcode = LW;
  logic        mem_wr_ready = 1'b0;
  logic        store_buffer_match, full, mem_wr_valid;
  logic [14:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  mem_pkg::drain_state_e dbg_state;
  logic [2:0]  dbg_count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_opcode(st_opcode),
    .st_addr(st_addr), .st_data(st_data), .speculative(speculative),
    .prediction_success(prediction_success), .prediction_failed(prediction_failed),
    .search_store_buffer(search_store_buffer), .computed_addr(computed_addr),
    .search_opcode(search_opcode), .store_buffer_match(store_buffer_match),
    .full(full), .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // Scoreboard state
  typedef struct packed {
    logic        spec;
    logic [12:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } m_entry_t;

  m_entry_t    exp_q[$];
  logic [14:0] ret_log[$];
  int          checks = 0;
  int          failures = 0;
  int          idle_run = 0;
  logic        prev_hold = 1'b0;
  logic [14:0] prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_be;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic is_st(input logic [6:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [3:0] tb_mask(input logic [6:0] op, input logic [1:0] a);
    if (op == SB || op == LB || op == LBU) return 4'b0001 << a;
    if (op == SH || op == LH || op == LHU) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Byte b of the RAM word receives source byte (b - lowest written lane).
  function automatic logic [31:0] tb_data(input logic [6:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] r;
    int          base;
    be = tb_mask(op, a);
    r = '0;
    if (op == SB) base = int'(a);
    else if (op == SH) base = a[1] ? 2 : 0;
    else base = 0;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*(b-base) +: 8];
    return r;
  endfunction

  function automatic logic hit(input m_entry_t e, input logic [14:0] qa, input logic [6:0] qop);
    logic [3:0] m;
    m = tb_mask(qop, qa[1:0]);
    if (e.waddr != qa[14:2]) return 1'b0;
`ifdef STORE_BUFFER_BYTE_MATCH_EN
    return |(e.be & m);
`else
    return (m != 4'h0) || (e.be == e.be);
`endif
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    st_valid = 1'b0; st_opcode = '0; st_addr = '0; st_data = '0; speculative = 1'b0;
    prediction_success = 1'b0; prediction_failed = 1'b0;
    search_store_buffer = 1'b0; computed_addr = '0; search_opcode = LW;
  endtask

  task automatic set_store(input logic [6:0] op, input logic [14:0] a, input logic [31:0] d, input logic sp);
    st_valid = 1'b1; st_opcode = op; st_addr = a; st_data = d; speculative = sp;
  endtask

  task automatic set_search(input logic [14:0] a, input logic [6:0] op);
    search_store_buffer = 1'b1; computed_addr = a; search_opcode = op;
  endtask

  // One clock: score combinational outputs and the write handshake before the
  // edge, then advance the model and check count/full after it.
  task automatic cycle();
    logic     acc, exp_match, ret;
    m_entry_t inc, e;
    #1;
    if (prev_hold) begin
      check("hold_addr", mem_wr_addr, prev_addr);
      check("hold_data", mem_wr_data, prev_data);
      check("hold_be", mem_wr_be, prev_be);
    end
    acc = st_valid && is_st(st_opcode) && (exp_q.size() < DEPTH) && !(prediction_failed && speculative);
    inc.spec  = speculative && !prediction_success;
    inc.waddr = st_addr[14:2];
    inc.be    = tb_mask(st_opcode, st_addr[1:0]);
    inc.data  = tb_data(st_opcode, st_addr[1:0], st_data);
    exp_match = 1'b0;
    if (search_store_buffer) begin
      foreach (exp_q[i]) if (hit(exp_q[i], computed_addr, search_opcode)) exp_match = 1'b1;
      if (acc && hit(inc, computed_addr, search_opcode)) exp_match = 1'b1;
    end
    check("match", store_buffer_match, exp_match);
    if (mem_wr_valid) check("valid_has_store", exp_q.size() > 0, 1);
    if (exp_q.size() > 0 && !exp_q[0].spec && !mem_wr_valid) begin
      idle_run++;
      check("drain_latency", idle_run <= 2, 1);
    end else idle_run = 0;
    ret = mem_wr_valid && mem_wr_ready;
    if (ret && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wr_addr", mem_wr_addr, {e.waddr, 2'b00});
      check("wr_be", mem_wr_be, e.be);
      check("wr_data", mem_wr_data, e.data);
      check("wr_nonspec", e.spec, 1'b0);
      ret_log.push_back(mem_wr_addr);
    end
    prev_hold = mem_wr_valid && !mem_wr_ready;
    prev_addr = mem_wr_addr; prev_data = mem_wr_data; prev_be = mem_wr_be;
    @(posedge clk); #1;
    if (prediction_failed) while (exp_q.size() > 0 && exp_q[$].spec) void'(exp_q.pop_back());
    if (prediction_success) foreach (exp_q[i]) exp_q[i].spec = 1'b0;
    if (acc) exp_q.push_back(inc);
    check("count", dbg_count, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    set_search(15'h0100, LW);
    #1;
    check("reset_match", store_buffer_match, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    exp_q.delete();
    prev_hold = 1'b0;
    idle_run = 0;
    check("reset_count", dbg_count, 0);
    check("reset_full", full, 0);
    check("reset_valid", mem_wr_valid, 0);
    check("reset_addr", mem_wr_addr, 0);
    check("reset_data", mem_wr_data, 0);
    check("reset_be", mem_wr_be, 0);
    check("reset_state", dbg_state, mem_pkg::DRAIN_IDLE);
  endtask

  task automatic drain(input int max_cycles);
    clear_inputs();
    mem_wr_ready = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      if (exp_q.size() == 0 && !mem_wr_valid) break;
      cycle();
    end
    check("drain_done", (exp_q.size() == 0) && !mem_wr_valid, 1);
  endtask

  // Directed steps, then random traffic
  initial begin
    logic [6:0] ops [4];
    logic       pend;
    int         res;
    ops = '{SB, SH, SW, LW};

    do_reset();

    // Basic drain: valid two cycles after enqueue
    mem_wr_ready = 1'b1;
    set_store(SW, 15'h0100, 32'hDEADBEEF, 1'b0);
    cycle();
    clear_inputs();
    check("basic_n1_valid", mem_wr_valid, 0);
    cycle();
    check("basic_n2_valid", mem_wr_valid, 1);
    check("basic_addr", mem_wr_addr, 15'h0100);
    check("basic_be", mem_wr_be, 4'hF);
    check("basic_data", mem_wr_data, 32'hDEADBEEF);
    cycle();
    check("basic_count_end", dbg_count, 0);
    check("basic_valid_end", mem_wr_valid, 0);

    // Lane formatting
    set_store(SH, 15'h0206, 32'h00001234, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("sh_valid", mem_wr_valid, 1);
    check("sh_addr", mem_wr_addr, 15'h0204);
    check("sh_be", mem_wr_be, 4'b1100);
    check("sh_data", mem_wr_data, 32'h12340000);
    drain(10);

    // Word match and bypass
    mem_wr_ready = 1'b0;
    set_store(SB, 15'h0103, 32'h000000AB, 1'b0);
    set_search(15'h0100, LW);
    #1 check("bypass_match", store_buffer_match, 1);
    cycle();
    clear_inputs();
    set_search(15'h0100, LB);
`ifdef STORE_BUFFER_BYTE_MATCH_EN
    #1 check("lb_0100_match", store_buffer_match, 0);
`else
    #1 check("lb_0100_match", store_buffer_match, 1);
`endif
    set_search(15'h0104, LW);
    #1 check("w_0104_match", store_buffer_match, 0);
    set_search(15'h0103, LB);
    #1 check("lb_0103_match", store_buffer_match, 1);
    cycle();
    drain(10);

    // Flush of speculative tail
    mem_wr_ready = 1'b0;
    set_store(SW, 15'h0010, 32'h11111111, 1'b0); cycle();
    set_store(SW, 15'h0020, 32'h22222222, 1'b0); cycle();
    set_store(SW, 15'h0030, 32'h33333333, 1'b1); cycle();
    set_store(SW, 15'h0040, 32'h44444444, 1'b1); cycle();
    clear_inputs();
    prediction_failed = 1'b1;
    set_search(15'h0030, LW);
    #1 check("flush_same_cycle_match", store_buffer_match, 1);
    cycle();
    clear_inputs();
    check("flush_count", dbg_count, 2);
    set_search(15'h0030, LW);
    #1 check("flush_gone_match", store_buffer_match, 0);
    set_search(15'h0010, LW);
    #1 check("flush_kept_match", store_buffer_match, 1);
    cycle();
    ret_log.delete();
    drain(20);
    check("flush_retired", ret_log.size(), 2);
    if (ret_log.size() == 2) begin
      check("flush_first", ret_log[0], 15'h0010);
      check("flush_second", ret_log[1], 15'h0020);
    end

    // Full
    mem_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_store(SW, 15'(15'h0200 + 4*i), $urandom, 1'b0);
      cycle();
      check("full_flag", full, i >= 3);
    end
    check("full_count", dbg_count, 4);
    mem_wr_ready = 1'b1;
    set_store(SW, 15'h0300, 32'hA5A5A5A5, 1'b0);
    cycle();
    check("full_retire_count", dbg_count, 3);
    set_store(SW, 15'h0304, 32'h5A5A5A5A, 1'b0);
    cycle();
    check("enq_retire_count", dbg_count, 3);
    drain(20);

    // Speculative stores released by prediction_success
    mem_wr_ready = 1'b1;
    set_store(SW, 15'h0500, 32'h50505050, 1'b1); cycle();
    set_store(SW, 15'h0504, 32'h50405040, 1'b1); cycle();
    clear_inputs();
    cycle();
    check("spec_held_valid", mem_wr_valid, 0);
    prediction_success = 1'b1;
    cycle();
    clear_inputs();
    check("release_n1_valid", mem_wr_valid, 0);
    cycle();
    check("release_first_valid", mem_wr_valid, 1);
    check("release_first_addr", mem_wr_addr, 15'h0500);
    cycle();
    check("release_second_valid", mem_wr_valid, 1);
    check("release_second_addr", mem_wr_addr, 15'h0504);
    cycle();
    check("release_done_valid", mem_wr_valid, 0);

    // Reset while a write is pending
    mem_wr_ready = 1'b0;
    set_store(SW, 15'h0600, 32'h66666666, 1'b0); cycle();
    clear_inputs(); cycle();
    check("midwrite_valid", mem_wr_valid, 1);
    do_reset();

    // Random traffic
    pend = 1'b0;
    for (int n = 0; n < 800; n++) begin
      clear_inputs();
      res = int'($urandom_range(0, 11));
      prediction_success = (res == 0);
      prediction_failed  = (res == 1);
      st_valid  = 1'($urandom_range(0, 1));
      st_opcode = ops[$urandom_range(0, 3)];
      st_addr   = 15'($urandom_range(0, 47));
      st_data   = $urandom;
      speculative = (pend && res > 1) ? 1'b1 : 1'($urandom_range(0, 1));
      search_store_buffer = 1'($urandom_range(0, 1));
      computed_addr = 15'($urandom_range(0, 47));
      search_opcode = 7'($urandom_range(11, 15));
      mem_wr_ready  = ($urandom_range(0, 3) != 0);
      cycle();
      if (res <= 1) pend = 1'b0;
      else if (st_valid && speculative) pend = 1'b1;
    end
    clear_inputs();
    prediction_success = 1'b1;
    cycle();
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
